decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- RV32I decode pipeline stage; sits directly downstream of the core fetch stage.
- Takes the fetched instruction word plus its word address and registers a decoded bundle for the backend: register indices, sign-extended immediate, op class, write-enable and illegal flag.
- Provides a 1-entry skid buffer and a ready/valid handshake so that a backend stall never drops an instruction.
- Honours backend flush on redirect.

Parameters:
- ADDR_WIDTH, 32, byte-address width; addresses carried as word address [ADDR_WIDTH-1:2].

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- flush  in  1  backend redirect; kills all held and incoming instructions
- in_valid  in  1  fetch output valid
- in_addr  in  ADDR_WIDTH-2  instruction word address
- in_insn  in  32  instruction word
- in_ready  out  1  stage can accept; fetch must hold or stop when low
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  backend accepts bundle
- out_addr  out  ADDR_WIDTH-2  instruction word address
- out_insn  out  32  raw instruction
- out_rd  out  5  insn[11:7]
- out_rs1  out  5  insn[19:15]
- out_rs2  out  5  insn[24:20]
- out_imm  out  32  sign-extended immediate
- out_op_class  out  4  op class code
- out_rd_we  out  1  writes rd
- out_illegal  out  1  illegal encoding

Behaviour:
- Reset values: out_valid=0, skid_valid=0, in_ready=1, all data outputs 0.
- Accept condition: in_valid & in_ready. in_ready = ~skid_valid, registered.
- Latency: 1 cycle from accept to out_valid when the output register is free or draining.
- Output register load rule: the output register loads the decoded input when out_valid=0 or out_ready=1.
- Stall with new input: if out_valid=1, out_ready=0 and an accept occurs, the decoded input goes into the skid register (skid_valid=1).
- Skid drain: when the output fires (out_valid & out_ready) and skid_valid=1, skid moves to the output and skid_valid clears. Input is blocked that cycle because in_ready=0.
- Output hold: bundle stays stable while out_valid & ~out_ready.
- Flush: next cycle out_valid=0 and skid_valid=0. Input presented in the flush cycle is discarded. in_ready=1 the cycle after flush.
- Priority: rst > flush > normal.
- Decode is done combinationally on in_insn before registering. Op class by insn[6:0]:
  - 0110111 LUI=0
  - 0010111 AUIPC=1
  - 1101111 JAL=2
  - 1100111 JALR=3
  - 1100011 BRANCH=4
  - 0000011 LOAD=5
  - 0100011 STORE=6
  - 0010011 OP_IMM=7
  - 0110011 OP=8
  - 0001111 FENCE=9
  - 1110011 SYSTEM=10
  - anything else ILLEGAL=15
- Immediate by format, all sign-extended from insn[31]:
  - I (JALR, LOAD, OP_IMM, SYSTEM, FENCE)
  - S (STORE)
  - B (BRANCH, bit0=0)
  - U (LUI, AUIPC; low 12 bits=0)
  - J (JAL, bit0=0)
  - OP: imm=0
- out_illegal=1 and out_op_class=15 when any of:
  - insn[1:0] != 2'b11
  - unknown opcode
  - BRANCH funct3 in {010,011}
  - LOAD funct3 in {011,110,111}
  - STORE funct3 > 010
  - JALR funct3 != 000
  - OP funct7 not in {0000000,0100000}
  - OP funct7=0100000 with funct3 not in {000,101}
  - OP_IMM shift (funct3 001/101) with bad funct7
- out_rd_we=1 iff class in {LUI, AUIPC, JAL, JALR, LOAD, OP_IMM, OP}, rd != 0 and not illegal.
- Illegal instructions still flow through as valid bundles; the backend raises the exception.
- Reset mid-operation: held bundles are dropped with no output pulse.

Test Plan:
- Reset sequence:
  - Stimulus: rst=1 for 2 cycles, then release.
  - Required: out_valid=0, in_ready=1, out_imm=0 throughout; in_ready=1 on the first cycle after release.
- Streaming with out_ready=1:
  - Stimulus: in_insn=0x00500093 (addi x1,x0,5), addr 0x100; next 0xFE000EE3 (beq x0,x0,-4).
  - Required: one cycle later out_op_class=7, rd=1, imm=5, rd_we=1; then op_class=4, imm=0xFFFFFFFC, rd_we=0.
- Stall/skid:
  - Stimulus: out_ready=0 while two instructions A, B are accepted.
  - Required: out holds A, B goes into skid, in_ready=0; when out_ready=1, A is taken, then B is presented next cycle with in_ready=1 again; no loss, no duplication.
- Flush:
  - Stimulus: out and skid both valid, flush=1 with in_valid=1.
  - Required: next cycle out_valid=0, in_ready=1; the flushed input never appears at the output.
- Illegal encodings:
  - Stimulus: 0x00000000, 0x0000A003 (lw funct3=010 legal), 0x00003003 (funct3=011 load), 0x40001033 (sub funct3=001).
  - Required: illegal=1 for 0x00000000, 0x00003003 and 0x40001033; 0x0000A003 is legal LOAD.
- Immediates and rd_we:
  - Stimulus: lui x0,0x12345 = 0x12345037.
  - Required: op_class=0, imm=0x12345000, rd_we=0 because rd=0.
  - Stimulus: jal x1,+2048 = 0x001000EF.
  - Required: imm=0x00000800, rd_we=1.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes fetched words into a registered bundle and
// provides a ready/valid handshake with a one-entry skid buffer and flush.
module decode_stage #(
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   input  logic [ADDR_WIDTH-3:0] in_addr,
   input  logic [31:0]           in_insn,
   output logic                  in_ready,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_WIDTH-3:0] out_addr,
   output logic [31:0]           out_insn,
   output logic [4:0]            out_rd,
   output logic [4:0]            out_rs1,
   output logic [4:0]            out_rs2,
   output logic [31:0]           out_imm,
   output logic [3:0]            out_op_class,
   output logic                  out_rd_we,
   output logic                  out_illegal
);

   localparam int unsigned AW = ADDR_WIDTH - 2;

   localparam logic [3:0] CLS_LUI    = 4'd0;
   localparam logic [3:0] CLS_AUIPC  = 4'd1;
   localparam logic [3:0] CLS_JAL    = 4'd2;
   localparam logic [3:0] CLS_JALR   = 4'd3;
   localparam logic [3:0] CLS_BRANCH = 4'd4;
   localparam logic [3:0] CLS_LOAD   = 4'd5;
   localparam logic [3:0] CLS_STORE  = 4'd6;
   localparam logic [3:0] CLS_OP_IMM = 4'd7;
   localparam logic [3:0] CLS_OP     = 4'd8;
   localparam logic [3:0] CLS_FENCE  = 4'd9;
   localparam logic [3:0] CLS_SYSTEM = 4'd10;
   localparam logic [3:0] CLS_ILL    = 4'd15;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [31:0]   insn;
      logic [4:0]    rd;
      logic [4:0]    rs1;
      logic [4:0]    rs2;
      logic [31:0]   imm;
      logic [3:0]    op_class;
      logic          rd_we;
      logic          illegal;
   } bundle_t;

   bundle_t dec_c, out_q, out_n, skid_q, skid_n;
   logic    out_valid_q, out_valid_n, skid_valid_q, skid_valid_n;
   logic    in_ready_q, in_ready_n;
   logic    accept_c, load_out_c;

   logic [6:0]  opc;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [3:0]  cls;
   logic [31:0] imm;
   logic        bad;

   assign opc   = in_insn[6:0];
   assign f3    = in_insn[14:12];
   assign f7    = in_insn[31:25];
   assign imm_i = {{20{in_insn[31]}}, in_insn[31:20]};
   assign imm_s = {{20{in_insn[31]}}, in_insn[31:25], in_insn[11:7]};
   assign imm_b = {{19{in_insn[31]}}, in_insn[31], in_insn[7], in_insn[30:25], in_insn[11:8], 1'b0};
   assign imm_u = {in_insn[31:12], 12'b0};
   assign imm_j = {{11{in_insn[31]}}, in_insn[31], in_insn[19:12], in_insn[20], in_insn[30:21], 1'b0};

   // Opcode classification, immediate selection and encoding legality
   always_comb begin
      cls = CLS_ILL;
      imm = '0;
      bad = 1'b0;
      case (opc)
         7'b0110111: begin cls = CLS_LUI;    imm = imm_u; end
         7'b0010111: begin cls = CLS_AUIPC;  imm = imm_u; end
         7'b1101111: begin cls = CLS_JAL;    imm = imm_j; end
         7'b1100111: begin cls = CLS_JALR;   imm = imm_i; bad = (f3 != 3'b000); end
         7'b1100011: begin
            cls = CLS_BRANCH; imm = imm_b;
            bad = (f3 == 3'b010) || (f3 == 3'b011);
         end
         7'b0000011: begin
            cls = CLS_LOAD; imm = imm_i;
            bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
         end
         7'b0100011: begin cls = CLS_STORE;  imm = imm_s; bad = (f3 > 3'b010); end
         7'b0010011: begin
            cls = CLS_OP_IMM; imm = imm_i;
            if (f3 == 3'b001) bad = (f7 != 7'b0000000);
            if (f3 == 3'b101) bad = (f7 != 7'b0000000) && (f7 != 7'b0100000);
         end
         7'b0110011: begin
            cls = CLS_OP;
            bad = !((f7 == 7'b0000000) ||
                    ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))));
         end
         7'b0001111: begin cls = CLS_FENCE;  imm = imm_i; end
         7'b1110011: begin cls = CLS_SYSTEM; imm = imm_i; end
         default:    bad = 1'b1;
      endcase
      if (in_insn[1:0] != 2'b11) bad = 1'b1;
      if (bad) begin
         cls = CLS_ILL;
         imm = '0;
      end

      dec_c          = '0;
      dec_c.addr     = in_addr;
      dec_c.insn     = in_insn;
      dec_c.rd       = in_insn[11:7];
      dec_c.rs1      = in_insn[19:15];
      dec_c.rs2      = in_insn[24:20];
      dec_c.imm      = imm;
      dec_c.op_class = cls;
      dec_c.illegal  = bad;
      dec_c.rd_we    = !bad && (in_insn[11:7] != 5'd0) &&
                       ((cls == CLS_LUI) || (cls == CLS_AUIPC) || (cls == CLS_JAL) ||
                        (cls == CLS_JALR) || (cls == CLS_LOAD) || (cls == CLS_OP_IMM) ||
                        (cls == CLS_OP));
   end

   assign accept_c   = in_valid & in_ready_q;
   assign load_out_c = ~out_valid_q | out_ready;

   // Output/skid next state; skid is only ever full while the output is held
   always_comb begin
      out_n        = out_q;
      out_valid_n  = out_valid_q;
      skid_n       = skid_q;
      skid_valid_n = skid_valid_q;
      if (flush) begin
         out_valid_n  = 1'b0;
         skid_valid_n = 1'b0;
      end else if (load_out_c) begin
         if (skid_valid_q) begin
            out_n        = skid_q;
            out_valid_n  = 1'b1;
            skid_valid_n = 1'b0;
         end else begin
            out_valid_n = accept_c;
            if (accept_c) out_n = dec_c;
         end
      end else if (accept_c) begin
         skid_n       = dec_c;
         skid_valid_n = 1'b1;
      end
      in_ready_n = ~skid_valid_n;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q        <= '0;
         skid_q       <= '0;
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
      end else begin
         out_q        <= out_n;
         skid_q       <= skid_n;
         out_valid_q  <= out_valid_n;
         skid_valid_q <= skid_valid_n;
         in_ready_q   <= in_ready_n;
      end
   end

   assign in_ready     = in_ready_q;
   assign out_valid    = out_valid_q;
   assign out_addr     = out_q.addr;
   assign out_insn     = out_q.insn;
   assign out_rd       = out_q.rd;
   assign out_rs1      = out_q.rs1;
   assign out_rs2      = out_q.rs2;
   assign out_imm      = out_q.imm;
   assign out_op_class = out_q.op_class;
   assign out_rd_we    = out_q.rd_we;
   assign out_illegal  = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, out_ready;
   logic [29:0] in_addr;
   logic [31:0] in_insn;
   logic        in_ready, out_valid;
   logic [29:0] out_addr;
   logic [31:0] out_insn, out_imm;
   logic [4:0]  out_rd, out_rs1, out_rs2;
   logic [3:0]  out_op_class;
   logic        out_rd_we, out_illegal;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   decode_stage #(.ADDR_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_addr(in_addr), .in_insn(in_insn), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
      .out_insn(out_insn), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
      .out_imm(out_imm), .out_op_class(out_op_class), .out_rd_we(out_rd_we),
      .out_illegal(out_illegal)
   );

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_addr = '0; in_insn = '0;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_imm !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_hold: out_valid=%b in_ready=%b out_imm=%h required 0/1/0",
                     out_valid, in_ready, out_imm);
         end
      end
      rst = 1'b0;
      tick();
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_streaming();
      out_ready = 1'b1;
      in_valid = 1'b1; in_addr = 30'h100; in_insn = 32'h00500093;
      tick();
      in_addr = 30'h101; in_insn = 32'hFE000EE3;
      n_checks++;
      if (out_valid !== 1'b1 || out_op_class !== 4'd7 || out_rd !== 5'd1 ||
          out_imm !== 32'd5 || out_rd_we !== 1'b1 || out_addr !== 30'h100) begin
         n_fail++;
         $display("FAIL stream_addi: v=%b cls=%0d rd=%0d imm=%h we=%b addr=%h required 1/7/1/5/1/100",
                  out_valid, out_op_class, out_rd, out_imm, out_rd_we, out_addr);
      end
      tick();
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1 || out_op_class !== 4'd4 || out_imm !== 32'hFFFFFFFC ||
          out_rd_we !== 1'b0 || out_addr !== 30'h101) begin
         n_fail++;
         $display("FAIL stream_beq: v=%b cls=%0d imm=%h we=%b addr=%h required 1/4/fffffffc/0/101",
                  out_valid, out_op_class, out_imm, out_rd_we, out_addr);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL stream_drain: out_valid=%b required 0", out_valid);
      end
   endtask

   task automatic test_stall_skid();
      out_ready = 1'b0;
      in_valid = 1'b1; in_addr = 30'h200; in_insn = 32'h00700113;
      tick();
      in_addr = 30'h201; in_insn = 32'h00900193;
      n_checks++;
      if (out_valid !== 1'b1 || out_insn !== 32'h00700113 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL skid_first: v=%b insn=%h in_ready=%b required 1/00700113/1",
                  out_valid, out_insn, in_ready);
      end
      tick();
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1 || out_insn !== 32'h00700113 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL skid_full: v=%b insn=%h in_ready=%b required 1/00700113/0",
                  out_valid, out_insn, in_ready);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_insn !== 32'h00700113 || out_imm !== 32'd7 ||
          out_rd !== 5'd2 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL skid_hold: v=%b insn=%h imm=%h rd=%0d in_ready=%b required 1/00700113/7/2/0",
                  out_valid, out_insn, out_imm, out_rd, in_ready);
      end
      out_ready = 1'b1;
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_insn !== 32'h00900193 || out_addr !== 30'h201 ||
          out_rd !== 5'd3 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL skid_drain: v=%b insn=%h addr=%h rd=%0d in_ready=%b required 1/00900193/201/3/1",
                  out_valid, out_insn, out_addr, out_rd, in_ready);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL skid_nodup: out_valid=%b required 0", out_valid);
      end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      in_valid = 1'b1; in_addr = 30'h300; in_insn = 32'h00500093;
      tick();
      in_addr = 30'h301; in_insn = 32'h00700113;
      tick();
      flush = 1'b1; in_addr = 30'h302; in_insn = 32'h00900193;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_full: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
      end
      out_ready = 1'b1;
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_no_skid: out_valid=%b required 0", out_valid);
      end
      flush = 1'b1; in_valid = 1'b1; in_addr = 30'h303; in_insn = 32'h00500093;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_input: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_input_late: out_valid=%b required 0", out_valid);
      end
   endtask

   task automatic test_illegal();
      logic [31:0] insns [5] = '{32'h00000000, 32'h0000A003, 32'h00003003,
                                 32'h40001033, 32'h00002063};
      logic        ills  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      logic [3:0]  clss  [5] = '{4'd15, 4'd5, 4'd15, 4'd15, 4'd15};
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_addr = 30'(32'h400 + i); in_insn = insns[i];
         tick();
         in_valid = 1'b0;
         n_checks++;
         if (out_valid !== 1'b1 || out_illegal !== ills[i] || out_op_class !== clss[i] ||
             out_rd_we !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_%0d: insn=%h v=%b ill=%b cls=%0d we=%b required 1/%b/%0d/0",
                     i, insns[i], out_valid, out_illegal, out_op_class, out_rd_we, ills[i], clss[i]);
         end
      end
      tick();
   endtask

   task automatic test_immediates();
      logic [31:0] insns [3] = '{32'h12345037, 32'h001000EF, 32'h0020A423};
      logic [31:0] imms  [3] = '{32'h12345000, 32'h00000800, 32'h00000008};
      logic [3:0]  clss  [3] = '{4'd0, 4'd2, 4'd6};
      logic        wes   [3] = '{1'b0, 1'b1, 1'b0};
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_addr = 30'(32'h500 + i); in_insn = insns[i];
         tick();
         in_valid = 1'b0;
         n_checks++;
         if (out_valid !== 1'b1 || out_imm !== imms[i] || out_op_class !== clss[i] ||
             out_rd_we !== wes[i] || out_illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL imm_%0d: insn=%h v=%b imm=%h cls=%0d we=%b ill=%b required 1/%h/%0d/%b/0",
                     i, insns[i], out_valid, out_imm, out_op_class, out_rd_we, out_illegal,
                     imms[i], clss[i], wes[i]);
         end
      end
      n_checks++;
      if (out_rs1 !== 5'd1 || out_rs2 !== 5'd2) begin
         n_fail++;
         $display("FAIL store_regs: rs1=%0d rs2=%0d required 1/2", out_rs1, out_rs2);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      in_valid = 1'b1; in_addr = 30'h600; in_insn = 32'h00500093;
      tick();
      in_insn = 32'h00700113;
      tick();
      in_valid = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_insn !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_mid: v=%b in_ready=%b insn=%h required 0/1/0",
                  out_valid, in_ready, out_insn);
      end
      out_ready = 1'b1;
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_drop: out_valid=%b required 0", out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_stall_skid();
      test_flush();
      test_illegal();
      test_immediates();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
